pair_detect_arbiter: RTL and testbench
======================================

Name: pair_detect_arbiter

Overview:
- Shares one consecutive-equal-bit detector (Mealy, states A/B/C) among NREQ serial bit-stream requesters.
- Round-robin arbiter grants one requester at a time and runs the detector over a frame of that requester's bits.
- Counts detector matches over the frame, then reports the count with a one-cycle done pulse.
- Sits between the serial front-ends and the status/statistics logic.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LEN_W, 8, width of each frame-length field.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester frame request; hold high until the matching done pulse.
- frame_len  input  NREQ*LEN_W  per-requester frame length in bits; field i is bits [i*LEN_W +: LEN_W].
- bit_in  input  NREQ  per-requester serial data bit; the granted requester presents one new bit per cycle in RUN.
- gnt  output  NREQ  one-hot grant; all zeros when not granted.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse marking the end of the granted frame.
- match_cnt  output  CNT_W  matches counted in the last completed frame; held until the next done.

Behaviour:
- Reset (asynchronous, active-high):
  - gnt=0, busy=0, done=0, match_cnt=0.
  - FSM goes to IDLE and the detector to A.
  - Round-robin pointer is set so requester 0 has highest priority.
  - Reset asserted mid-frame aborts the frame with no done pulse.
- States: IDLE, RUN, DONE. The state register has a default branch that returns to IDLE.
- IDLE:
  - If any req bit is high, grant the first requester at or above (last_grant+1) mod NREQ, searching upward with wrap.
  - On that edge: gnt=onehot(k), latch len=frame_len[k], clear count, set detector to A.
  - If len==0, go to DONE; otherwise go to RUN.
  - If no req bit is high, stay in IDLE with gnt=0.
- RUN:
  - Each cycle, sample bit_in[k] and advance the detector:
    - A: 1->C, 0->B, no match.
    - B: 0->B with match, 1->C.
    - C: 1->C with match, 0->B.
  - The first bit of a frame can never match.
  - On a match, count += 1, saturating at 2^CNT_W-1.
  - Decrement the remaining-bit counter. After len bits have been sampled, go to DONE.
  - gnt stays constant during RUN. Changes on other requesters' req or bit_in are ignored.
- DONE (exactly one cycle):
  - done=1, match_cnt=count (visible in this same cycle), gnt still asserted.
  - last_grant=k; next state is IDLE, and gnt clears on that edge.
- Timing:
  - req high in IDLE at edge t: gnt high from t+1, bits sampled at edges t+1 .. t+len.
  - done is high for the cycle after edge t+len.
  - The next grant is issued at the edge after IDLE is re-entered, i.e. at least 2 cycles after done.
- req deasserted by the granted requester mid-frame has no effect; the frame completes.
- A requester that keeps req high after done is re-eligible, but at lowest priority after rotation.
- Simultaneous requests: exactly one grant, chosen by pointer order. No requester is starved; the worst case is NREQ-1 frames ahead of it.

Test Plan:
- Reset, single requester: req=0001, len0=6, bits 0,0,1,1,1,0 -> gnt=0001 for 7 cycles, done once, match_cnt=3.
- Round-robin: req=1111 held, all len=2 -> grant order 0001, 0010, 0100, 1000, 0001; gnt never has two bits set.
- Zero length: req=0100, len2=0 -> gnt=0100 for 1 cycle, done in that cycle, match_cnt=0, busy high only in DONE.
- Saturation: CNT_W=2, len=8, bits all 1 -> 7 matches, match_cnt=3.
- Mid-frame reset: assert reset in cycle 3 of an 8-bit frame -> gnt=0, busy=0, done never pulses, match_cnt=0; after release, requester 0 wins over requester 2.
- Bus isolation: granted requester 1 with bits 1,0,1,0 (match_cnt=0) while bit_in[0] toggles randomly -> match_cnt=0; match_cnt holds 0 until the next done.

Source files
------------

// File: rtl/pair_detect_arbiter.sv
// Round-robin arbiter that lends one shared consecutive-equal-bit detector to
// NREQ serial requesters and reports the match count of each granted frame.
module pair_detect_arbiter #(
  parameter int NREQ  = 4,
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] frame_len,
  input  logic [NREQ-1:0]       bit_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      match_cnt
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {DET_A = 2'd0, DET_B = 2'd1, DET_C = 2'd2} det_t;

  // Handshake: a requester raises req and holds it until its done pulse; gnt is
  // the acknowledgement and stays fixed from the grant edge through DONE.
  state_t             state;
  det_t               det;
  det_t               det_next;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   last_grant;
  logic [LEN_W-1:0]   remaining;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   cnt_next;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic [LEN_W-1:0]   pick_len;
  logic               cur_bit;
  logic               hit;

  // Scan from the lowest priority offset upward so the last hit is the winner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant) + i) % NREQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pick_len = frame_len[pick_idx*LEN_W +: LEN_W];
  assign cur_bit  = bit_in[cur_idx];

  always_comb begin
    det_next = DET_A;
    hit      = 1'b0;
    case (det)
      DET_A: det_next = cur_bit ? DET_C : DET_B;
      DET_B: begin
        det_next = cur_bit ? DET_C : DET_B;
        hit      = ~cur_bit;
      end
      DET_C: begin
        det_next = cur_bit ? DET_C : DET_B;
        hit      = cur_bit;
      end
      default: det_next = DET_A;
    endcase
  end

  assign cnt_next = (hit && (count != {CNT_W{1'b1}})) ? count + 1'b1 : count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      det        <= DET_A;
      cur_idx    <= '0;
      last_grant <= IDX_W'(NREQ - 1);
      remaining  <= '0;
      count      <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      match_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            cur_idx   <= pick_idx;
            gnt       <= NREQ'(1) << pick_idx;
            remaining <= pick_len;
            count     <= '0;
            det       <= DET_A;
            busy      <= 1'b1;
            if (pick_len == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              match_cnt <= '0;
            end else begin
              state <= RUN;
            end
          end else begin
            gnt  <= '0;
            busy <= 1'b0;
          end
        end
        RUN: begin
          det       <= det_next;
          count     <= cnt_next;
          remaining <= remaining - 1'b1;
          if (remaining == LEN_W'(1)) begin
            state     <= DONE;
            done      <= 1'b1;
            match_cnt <= cnt_next;
          end
        end
        DONE: begin
          last_grant <= cur_idx;
          state      <= IDLE;
          gnt        <= '0;
          busy       <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pair_detect_arbiter.sv
// Bench for pair_detect_arbiter: spec vectors, corner sequences and randomized
// frames checked against a pair-counting / round-robin reference model.
`timescale 1ns/1ps
module tb_pair_detect_arbiter;

  localparam int NREQ  = 4;
  localparam int LEN_W = 8;
  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]       req;
  logic [31:0]      frame_len;
  logic [3:0]       bit_in;
  logic [3:0]       gnt;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_cnt;

  logic [3:0]  req_s;
  logic [31:0] frame_len_s;
  logic [3:0]  bit_in_s;
  logic [3:0]  gnt_s;
  logic        busy_s;
  logic        done_s;
  logic [1:0]  match_cnt_s;

  pair_detect_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .req(req), .frame_len(frame_len), .bit_in(bit_in),
    .gnt(gnt), .busy(busy), .done(done), .match_cnt(match_cnt)
  );

  pair_detect_arbiter #(.NREQ(4), .LEN_W(8), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .req(req_s), .frame_len(frame_len_s), .bit_in(bit_in_s),
    .gnt(gnt_s), .busy(busy_s), .done(done_s), .match_cnt(match_cnt_s)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int last_m   = 3;
  int last_cnt = 0;
  logic [CNT_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_count(input logic [15:0] b, input int len, input int cw);
    int n;
    int cap;
    n = 0;
    for (int i = 1; i < len; i++)
      if (b[i] == b[i-1]) n++;
    cap = (1 << cw) - 1;
    return (n > cap) ? cap : n;
  endfunction

  function automatic int model_pick(input logic [3:0] r, input int last);
    for (int off = 1; off <= 4; off++) begin
      int j;
      j = (last + off) % 4;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++)
      if (oh[i]) return i;
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    req    = '0;
    bit_in = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_match_cnt", 32'(match_cnt), 32'd0);
    reset    = 1'b0;
    last_m   = 3;
    last_cnt = 0;
    exp_q.delete();
  endtask

  // Called at a negedge in IDLE with req already driven; the next edge grants k.
  task automatic frame(input string tag, input int k, input int len, input logic [15:0] bits,
                       input bit drop, input bit jitter, input int exp_cnt);
    logic [31:0] got;
    exp_q.push_back(CNT_W'(exp_cnt));
    check({tag, "_idle_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    for (int c = 0; c <= len; c++) begin
      @(negedge clk);
      check({tag, "_gnt"}, 32'(gnt), 32'(1 << k));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_done"}, 32'(done), 32'(c == len));
      if (c == len) begin
        got = 32'(exp_q.pop_front());
        check({tag, "_match_cnt"}, 32'(match_cnt), got);
        last_cnt = int'(got);
      end else begin
        check({tag, "_match_cnt_hold"}, 32'(match_cnt), 32'(last_cnt));
      end
      if (c == 0) begin
        if (jitter) begin
          req       = 4'($urandom);
          frame_len = 32'($urandom);
        end
        if (jitter || drop) req[k[1:0]] = !drop;
      end
      bit_in = 4'($urandom);
      if (c < len) bit_in[k[1:0]] = bits[c[3:0]];
    end
    @(negedge clk);
    check({tag, "_end_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
    check({tag, "_end_done"}, 32'(done), 32'd0);
    check({tag, "_end_match_cnt"}, 32'(match_cnt), 32'(last_cnt));
    last_m = k;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  exp_gnt;
    int          len;
    logic [15:0] bits;
    bit          drop;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    int          len;
    logic [15:0] b;
    bit          drop;
    bit          seen;
    int          gcyc;
    logic [1:0]  sat_got;

    vecs[0] = '{4'b0001, 4'b0001, 6, 16'h001C, 1'b0, 3};
    vecs[1] = '{4'b0100, 4'b0100, 0, 16'h0000, 1'b0, 0};
    vecs[2] = '{4'b0010, 4'b0010, 4, 16'h0005, 1'b0, 0};
    vecs[3] = '{4'b1001, 4'b1000, 3, 16'h0007, 1'b0, 2};
    vecs[4] = '{4'b1001, 4'b0001, 5, 16'h0000, 1'b0, 4};
    vecs[5] = '{4'b0110, 4'b0010, 3, 16'h0004, 1'b1, 1};
    vecs[6] = '{4'b1111, 4'b0100, 1, 16'h0001, 1'b0, 0};
    vecs[7] = '{4'b0011, 4'b0001, 2, 16'h0003, 1'b0, 1};

    req = '0; frame_len = '0; bit_in = '0;
    req_s = '0; frame_len_s = '0; bit_in_s = '0;

    do_reset();
    check("rst_sat_match_cnt", 32'(match_cnt_s), 32'd0);

    for (int v = 0; v < 8; v++) begin
      k         = onehot_idx(vecs[v].exp_gnt);
      req       = vecs[v].req;
      frame_len = 32'($urandom);
      frame_len[k*8 +: 8] = 8'(vecs[v].len);
      frame($sformatf("vec%0d", v), k, vecs[v].len, vecs[v].bits, vecs[v].drop, 1'b1,
            vecs[v].exp_cnt);
    end

    // Round robin with every requester held high and all lengths 2.
    do_reset();
    req       = 4'hF;
    frame_len = {4{8'd2}};
    for (int i = 0; i < 5; i++) begin
      b = 16'($urandom);
      frame($sformatf("rr%0d", i), i % 4, 2, b, 1'b0, 1'b0, model_count(b, 2, CNT_W));
    end

    // Reset in the third cycle of an 8-bit frame aborts it silently.
    req       = 4'b0001;
    frame_len = 32'h0000_0008;
    repeat (3) begin
      @(negedge clk);
      bit_in = 4'($urandom);
    end
    check("mf_gnt_pre", 32'(gnt), 32'd1);
    reset = 1'b1;
    #1;
    check("mf_gnt", 32'(gnt), 32'd0);
    check("mf_busy", 32'(busy), 32'd0);
    check("mf_done", 32'(done), 32'd0);
    check("mf_match_cnt", 32'(match_cnt), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("mf_done_held", 32'(done), 32'd0);
    end
    req       = 4'b0101;
    frame_len = 32'h0005_0003;
    reset     = 1'b0;
    last_m    = 3;
    last_cnt  = 0;
    exp_q.delete();
    b = 16'($urandom);
    frame("mf_after", 0, 3, b, 1'b0, 1'b0, model_count(b, 3, CNT_W));

    // Randomized frames against the model.
    for (int it = 0; it < 40; it++) begin
      req = 4'($urandom_range(1, 15));
      for (int f = 0; f < 4; f++) frame_len[f*8 +: 8] = 8'($urandom_range(0, 15));
      k    = model_pick(req, last_m);
      len  = int'(frame_len[k*8 +: 8]);
      b    = 16'($urandom);
      drop = ($urandom_range(0, 3) == 0);
      frame($sformatf("rnd%0d", it), k, len, b, drop, 1'b1, model_count(b, len, CNT_W));
    end
    req = '0;

    // Saturation on the 2-bit counter instance.
    req_s       = 4'b0001;
    frame_len_s = 32'd8;
    bit_in_s    = 4'hF;
    seen        = 1'b0;
    gcyc        = 0;
    sat_got     = '0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      check("sat_busy", 32'(busy_s), 32'(gnt_s != 4'd0));
      if (gnt_s != 4'd0) gcyc++;
      if (done_s) begin
        seen    = 1'b1;
        sat_got = match_cnt_s;
        req_s   = '0;
      end
    end
    check("sat_done_seen", 32'(seen), 32'd1);
    check("sat_match_cnt", 32'(sat_got), 32'd3);
    check("sat_gnt_cycles", 32'(gcyc), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
